logic_op_responder: RTL

LOGIC_OP_RESPONDER -- requirements
Module: logic_op_responder

---
 rtl/logic_op_pkg.sv | 32 +++
 rtl/logic_op_responder_if.sv | 27 ++
 rtl/logic_op_comb.sv | 26 ++
 rtl/logic_op_responder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared encodings for the logic-op responder: opcodes, FSM states and width default.
// The SHIFT state exists only when LOGIC_OP_SHIFT_EN is defined.
package logic_op_pkg;

  localparam int LOGIC_OP_WIDTH = 32;
  localparam int AMT_W          = 5;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_NOT = 3'b100,
    OP_SHR = 3'b101,
    OP_SHL = 3'b110,
    OP_ROR = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef LOGIC_OP_SHIFT_EN
    ST_SHIFT = 2'd1,
`endif
    ST_RESP  = 2'd2
  } state_e;

  // Opcodes 101..111 are the shift group.
  function automatic logic is_shift(input logic [2:0] op);
    return op[2] & (op[1] | op[0]);
  endfunction

endpackage

// File: rtl/logic_op_responder_if.sv
// Request/response handshake bundle between an initiator (master) and the responder (slave).
interface logic_op_responder_if #(
  parameter int WIDTH = logic_op_pkg::LOGIC_OP_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] z;
  logic             zero;
  logic             err;

  modport master (
    output req_valid, op, a, b, resp_ready,
    input  req_ready, resp_valid, z, zero, err
  );

  modport slave (
    input  req_valid, op, a, b, resp_ready,
    output req_ready, resp_valid, z, zero, err
  );

endinterface

// File: rtl/logic_op_comb.sv
// Single-cycle bitwise unit for opcodes 000..100; any other opcode yields zero.
module logic_op_comb
  import logic_op_pkg::*;
#(
  parameter int WIDTH = LOGIC_OP_WIDTH
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_z
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_z and no latch is inferred.
    o_z = '0;
    case (i_op)
      OP_AND:  o_z = i_a & i_b;
      OP_OR:   o_z = i_a | i_b;
      OP_XOR:  o_z = i_a ^ i_b;
      OP_NOR:  o_z = ~(i_a | i_b);
      OP_NOT:  o_z = ~i_a;
      default: o_z = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_responder.sv
// Handshaked logic/shift responder: IDLE -> (SHIFT) -> RESP, one result per request.
// Shift ops (101..111) are built only with LOGIC_OP_SHIFT_EN; otherwise they return err.
module logic_op_responder
  import logic_op_pkg::*;
#(
  parameter int WIDTH = LOGIC_OP_WIDTH
) (
  input  logic                clk,
  input  logic                clr,
  logic_op_responder_if.slave bus
);

  state_e           r_state;
  logic [WIDTH-1:0] r_z;
  logic             r_err;
  logic             r_resp_valid;
  logic             r_req_ready;

  logic             w_accept;
  logic [WIDTH-1:0] w_logic_z;

  assign w_accept = bus.req_valid & r_req_ready;

  logic_op_comb #(.WIDTH(WIDTH)) u_comb (
    .i_op (bus.op),
    .i_a  (bus.a),
    .i_b  (bus.b),
    .o_z  (w_logic_z)
  );

`ifdef LOGIC_OP_SHIFT_EN
  logic [2:0]       r_op;
  logic [AMT_W-1:0] r_cnt;
  logic [AMT_W-1:0] w_amt;
  logic [WIDTH-1:0] w_shift_z;

  assign w_amt = bus.b[AMT_W-1:0];

  // One-bit step of the shift that was latched at acceptance.
  always_comb begin
    w_shift_z = r_z;
    case (r_op)
      OP_SHR:  w_shift_z = {1'b0, r_z[WIDTH-1:1]};
      OP_SHL:  w_shift_z = {r_z[WIDTH-2:0], 1'b0};
      OP_ROR:  w_shift_z = {r_z[0], r_z[WIDTH-1:1]};
      default: w_shift_z = r_z;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
      r_state      <= ST_IDLE;
      r_z          <= '0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_req_ready  <= 1'b1;
`ifdef LOGIC_OP_SHIFT_EN
      r_op         <= '0;
      r_cnt        <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
`ifdef LOGIC_OP_SHIFT_EN
            r_op  <= bus.op;
            r_cnt <= w_amt;
            r_err <= 1'b0;
            if (is_shift(bus.op)) begin
              r_z <= bus.a;
              if (w_amt == '0) begin
                r_state      <= ST_RESP;
                r_resp_valid <= 1'b1;
              end else begin
                r_state <= ST_SHIFT;
              end
            end else begin
              r_z          <= w_logic_z;
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
            end
`else
            r_z          <= is_shift(bus.op) ? '0 : w_logic_z;
            r_err        <= is_shift(bus.op);
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
`endif
          end
        end

`ifdef LOGIC_OP_SHIFT_EN
        ST_SHIFT: begin
          r_z   <= w_shift_z;
          r_cnt <= r_cnt - AMT_W'(1);
          // The step taken while the counter reads 1 is the last one.
          if (r_cnt == AMT_W'(1)) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
          end
        end
`endif

        ST_RESP: begin
          if (bus.resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.z          = r_z;
  assign bus.err        = r_err;
  assign bus.zero       = r_resp_valid & (r_z == '0);

endmodule
